binary16_div_arbiter: RTL and testbench
=======================================

// Module: binary16_div_arbiter
// PURPOSE
// Shares one binary16_div unit between NUM_REQ requesters (e.g. physics-update lanes).
// Round-robin grant; issues one division at a time and waits for its result.
// Returns the result to the granted requester, guarded by a completion watchdog.
// Sits between the requester lanes and the divider's data_valid_in/data_valid_out interface.
// PARAMETERS
// NUM_REQ  4   number of requesters (2..8); ID_W = $clog2(NUM_REQ)
// TIMEOUT  32  max WAIT cycles for div_valid_out before abort (divider takes ~24)
// PORTS
// clk_in          in   1           clock
// rst             in   1           asynchronous, active-high reset
// req_valid       in   NUM_REQ     per-requester request; hold until req_ready
// req_a           in   16*NUM_REQ  dividends, lane i at [16*i+:16]
// req_b           in   16*NUM_REQ  divisors, lane i at [16*i+:16]
// req_ready       out  NUM_REQ     one-hot accept pulse (combinational, IDLE only)
// resp_valid      out  NUM_REQ     one-hot result pulse, 1 cycle, no backpressure
// resp_result     out  16          quotient for the lane flagged in resp_valid
// div_a, div_b    out  16 each     operands to divider, registered
// div_valid_in    out  1           1-cycle start pulse to divider
// div_result      in   16          divider result
// div_valid_out   in   1           divider done pulse
// busy            out  1           high in any state except IDLE
// timeout_err     out  1           1-cycle pulse when the watchdog fires
// BEHAVIOUR
// - Reset (async): state=IDLE, rr_ptr=0, cnt=0, div_a/div_b=0, resp_result=0.
//   Also div_valid_in=0, resp_valid=0, timeout_err=0 and busy=0.
//   rst also drives the divider's reset; a mid-operation reset abandons the division silently.
// - FSM states: IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE.
// - IDLE: scan req_valid from rr_ptr upward, wrapping modulo NUM_REQ; the first set bit is g.
//   If a grant is made: req_ready[g]=1 this cycle; latch a/b into div_a/div_b; latch gid=g.
//   Same cycle: rr_ptr <= (g+1)%NUM_REQ and go to ISSUE.
//   If no req_valid is set: stay in IDLE; rr_ptr is unchanged.
// - ISSUE: div_valid_in=1 for exactly this cycle; cnt<=0; go to WAIT.
// - WAIT: cnt increments each cycle.
//   On div_valid_out: capture div_result into resp_result; go to RESPOND.
//   Else, when cnt==TIMEOUT-1: resp_result<=16'h7E00 (qNaN), timeout_err pulses next cycle, go to RESPOND.
//   If both happen in the same cycle, div_valid_out wins and there is no error.
// - RESPOND: resp_valid[gid]=1 for one cycle; go to IDLE. A new grant is possible the next cycle.
// - div_valid_out arriving outside WAIT is ignored.
// - Throughput: per op, 1 IDLE + 1 ISSUE + divider latency + 1 RESPOND cycle.
// - Requesters must not change a/b while req_valid=1 and ready=0.
//   A dropped req_valid simply loses eligibility; no state is kept for it.
// - Operands and result pass through untouched; no NaN/Inf/zero handling here.
// TESTING
// - Single request: lane 0, a=16'h4000, b=16'h3C00 -> req_ready[0] pulse, then div_valid_in 1 cycle later.
//   After that: resp_valid[0] 1 cycle after div_valid_out, with resp_result=16'h4000.
// - All four lanes request at once after reset -> grant order 0,1,2,3.
//   Lane 0 re-requests -> served after 3. Exactly one resp_valid per op.
// - Lanes 1 and 3 request with rr_ptr=2 -> lane 3 granted first, then lane 1; rr_ptr ends at 2.
// - Stub divider never answers -> timeout_err pulses 32 cycles after div_valid_in.
//   Same op: resp_result=16'h7E00 to the granted lane, FSM back to IDLE.
// - Assert rst during WAIT -> all outputs 0 immediately (async, no clock edge needed).
//   Next request after release is handled normally.
// - Spurious div_valid_out in IDLE -> no resp_valid, state unchanged.

Source files
------------

// File: rtl/binary16_div_arbiter.sv
// Round-robin arbiter sharing one binary16 divider between NUM_REQ requesters.
// One division in flight at a time; a watchdog aborts with qNaN if the divider never answers.
module binary16_div_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [15:0]            resp_result,
  output logic [15:0]            div_a,
  output logic [15:0]            div_b,
  output logic                   div_valid_in,
  input  logic [15:0]            div_result,
  input  logic                   div_valid_out,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [15:0] QNAN  = 16'h7E00;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StRespond} state_e;

  state_e            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   gid;
  logic [ID_W-1:0]   grant_id;
  logic              grant_found;
  logic [CNT_W-1:0]  cnt;

  // (base + off) mod NUM_REQ, valid for off < NUM_REQ and non-power-of-two NUM_REQ
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] base,
                                               input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return sum[ID_W-1:0];
  endfunction

  always_comb begin
    grant_found = 1'b0;
    grant_id    = rr_ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[wrap_inc(rr_ptr, i)]) begin
        grant_found = 1'b1;
        grant_id    = wrap_inc(rr_ptr, i);
      end
    end
  end

  assign req_ready = (state == StIdle && grant_found) ? (NUM_REQ'(1) << grant_id) : '0;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      rr_ptr       <= '0;
      gid          <= '0;
      cnt          <= '0;
      div_a        <= '0;
      div_b        <= '0;
      resp_result  <= '0;
      resp_valid   <= '0;
      div_valid_in <= 1'b0;
      timeout_err  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (grant_found) begin
            div_a        <= req_a[{grant_id, 4'b0000} +: 16];
            div_b        <= req_b[{grant_id, 4'b0000} +: 16];
            gid          <= grant_id;
            rr_ptr       <= wrap_inc(grant_id, 1);
            div_valid_in <= 1'b1;
            busy         <= 1'b1;
            state        <= StIssue;
          end
        end
        StIssue: begin
          div_valid_in <= 1'b0;
          cnt          <= '0;
          state        <= StWait;
        end
        StWait: begin
          cnt <= cnt + 1'b1;
          // A result arriving on the watchdog's last cycle still counts as success
          if (div_valid_out) begin
            resp_result <= div_result;
            resp_valid  <= NUM_REQ'(1) << gid;
            state       <= StRespond;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            resp_result <= QNAN;
            resp_valid  <= NUM_REQ'(1) << gid;
            timeout_err <= 1'b1;
            state       <= StRespond;
          end
        end
        StRespond: begin
          resp_valid  <= '0;
          timeout_err <= 1'b0;
          busy        <= 1'b0;
          state       <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_binary16_div_arbiter.sv
// Directed bench for binary16_div_arbiter; the bench itself plays the divider.
module tb_binary16_div_arbiter;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_a, req_b;
  logic [3:0]  req_ready, resp_valid;
  logic [15:0] resp_result, div_a, div_b, div_result;
  logic        div_valid_in, div_valid_out, busy, timeout_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] a_v [4];
  logic [15:0] b_v [4];

  binary16_div_arbiter #(.NUM_REQ(4), .TIMEOUT(32)) dut (
    .clk_in        (clk_in),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_result   (resp_result),
    .div_a         (div_a),
    .div_b         (div_b),
    .div_valid_in  (div_valid_in),
    .div_result    (div_result),
    .div_valid_out (div_valid_out),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int lane, input logic [15:0] a, input logic [15:0] b);
    a_v[lane] = a;
    b_v[lane] = b;
    req_a[16*lane +: 16] = a;
    req_b[16*lane +: 16] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    div_valid_out = 1'b0;
    div_result = '0;
    @(negedge clk_in);
    @(negedge clk_in);
    check("rst_outs", {req_ready, resp_valid, div_valid_in, busy, timeout_err}, 0);
    check("rst_data", {div_a, div_b}, 0);
    check("rst_result", resp_result, 0);
    rst = 1'b0;
  endtask

  // Called at a negedge in IDLE with req_valid already set; returns at a negedge back in IDLE.
  task automatic serve(input int lane, input int lat, input logic [15:0] res);
    #1;
    check("grant_ready", req_ready, 32'(1) << lane);
    check("idle_busy", busy, 0);
    @(negedge clk_in);
    req_valid[lane] = 1'b0;
    check("issue_valid", div_valid_in, 1);
    check("issue_ops", {div_a, div_b}, {a_v[lane], b_v[lane]});
    check("issue_busy", busy, 1);
    @(negedge clk_in);
    check("wait_valid", div_valid_in, 0);
    repeat (lat) @(negedge clk_in);
    div_valid_out = 1'b1;
    div_result = res;
    @(negedge clk_in);
    div_valid_out = 1'b0;
    div_result = '0;
    check("resp_valid", resp_valid, 32'(1) << lane);
    check("resp_result", resp_result, res);
    check("resp_noerr", timeout_err, 0);
    @(negedge clk_in);
    check("post_resp", {resp_valid, busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < 4; i++) set_ops(i, 16'h4000 + 16'(i), 16'h3C00 + 16'(i));
    do_reset();

    // Single request on lane 0
    set_ops(0, 16'h4000, 16'h3C00);
    req_valid = 4'b0001;
    serve(0, 3, 16'h4000);

    // Spurious divider pulse while idle is ignored
    div_valid_out = 1'b1;
    div_result = 16'h5555;
    @(negedge clk_in);
    div_valid_out = 1'b0;
    check("spur_resp", {resp_valid, busy, timeout_err}, 0);
    check("spur_result", resp_result, 16'h4000);
    @(negedge clk_in);
    check("spur_idle", {resp_valid, busy}, 0);

    // All four lanes at once after reset, lane 0 re-requests
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 16'h4100 + 16'(i), 16'h3C10 + 16'(i));
    req_valid = 4'b1111;
    serve(0, 1, 16'hA000);
    req_valid[0] = 1'b1;
    serve(1, 2, 16'hA001);
    serve(2, 0, 16'hA002);
    serve(3, 5, 16'hA003);
    serve(0, 1, 16'hA010);

    // Move rr_ptr to 2, then lanes 1 and 3 contend
    req_valid = 4'b0010;
    serve(1, 0, 16'hB001);
    req_valid = 4'b1010;
    serve(3, 0, 16'hB003);
    serve(1, 0, 16'hB011);
    req_valid = 4'b0110;
    serve(2, 0, 16'hB002);
    serve(1, 0, 16'hB021);

    // Divider never answers: watchdog aborts with qNaN
    set_ops(2, 16'h4400, 16'h0000);
    req_valid = 4'b0100;
    #1 check("to_ready", req_ready, 4'b0100);
    @(negedge clk_in);
    req_valid = '0;
    check("to_issue", div_valid_in, 1);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk_in);
      check("to_quiet", {resp_valid, timeout_err}, 0);
    end
    @(negedge clk_in);
    check("to_err", timeout_err, 1);
    check("to_resp", resp_valid, 4'b0100);
    check("to_qnan", resp_result, 16'h7E00);
    @(negedge clk_in);
    check("to_clear", {timeout_err, resp_valid, busy}, 0);

    // Result on the watchdog's final cycle wins, no error
    req_valid = 4'b1000;
    #1 check("tie_ready", req_ready, 4'b1000);
    @(negedge clk_in);
    req_valid = '0;
    @(negedge clk_in);
    repeat (31) @(negedge clk_in);
    div_valid_out = 1'b1;
    div_result = 16'h1234;
    @(negedge clk_in);
    div_valid_out = 1'b0;
    check("tie_resp", resp_valid, 4'b1000);
    check("tie_result", resp_result, 16'h1234);
    check("tie_noerr", timeout_err, 0);
    @(negedge clk_in);

    // Asynchronous reset in the middle of WAIT
    req_valid = 4'b0010;
    @(negedge clk_in);
    req_valid = '0;
    check("mid_issue", div_valid_in, 1);
    repeat (3) @(negedge clk_in);
    rst = 1'b1;
    #1;
    check("async_outs", {req_ready, resp_valid, div_valid_in, busy, timeout_err}, 0);
    check("async_data", {div_a, div_b, resp_result}, 0);
    @(negedge clk_in);
    rst = 1'b0;
    set_ops(3, 16'h3800, 16'h4000);
    req_valid = 4'b1000;
    serve(3, 2, 16'h3400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
